alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_ctrl
//  Description : Pushbutton-driven sequencer around a 16-entry instruction
//                FIFO feeding an ALU. In load mode (toggle=0) each button
//                press enqueues one entry. In execute mode (toggle=1) the
//                sequencer dequeues one opcode and strobes the ALU result
//                registers, walking IDLE -> RD -> WAIT -> EXEC.
//  Option      : ALU_SEQ_AUTORUN_EN -- when defined, execute mode drains the
//                queue without presses, one op every four cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       toggle,
  input  logic [2:0] opcode,
  output logic [3:0] wradder,
  output logic [3:0] radder,
  output logic       wen,
  output logic       ld_stb,
  output logic [4:0] count,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic [1:0] err
);

  localparam logic [4:0] DEPTH = 5'd16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WAIT = 2'd2,
    S_EXEC = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic       push_q;
  logic       push_edge;
  logic       start_cond;
  logic [3:0] wptr;
  logic [3:0] rptr;
  logic [2:0] op_q;
  logic       op_legal;
  logic       wen_q;
  logic       do_write;
  logic       do_drop;
  logic       do_deq;

  assign push_edge = push & ~push_q;

`ifdef ALU_SEQ_AUTORUN_EN
  // Execute mode keeps draining the queue on its own.
  assign start_cond = 1'b1;
`else
  // Each dequeue needs its own button press.
  assign start_cond = push_edge;
`endif

  // Opcodes 010 and 011 are reserved; everything else loads the ALU result.
  assign op_legal = (op_q[2:1] != 2'b01);

  // Presses only count in IDLE; in EXEC-mode sequences they are ignored.
  assign do_write = (state == S_IDLE) & ~toggle & push_edge & ~full;
  assign do_drop  = (state == S_IDLE) & ~toggle & push_edge & full;
  assign do_deq   = (state == S_EXEC);

  assign wradder = wptr;
  assign radder  = rptr;
  assign wen     = wen_q;
  assign full    = (count == DEPTH);
  assign empty   = (count == 5'd0);
  assign busy    = (state != S_IDLE);

  // State register; reset aborts any sequence in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic and the EXEC-cycle load strobe.
  always_comb begin
    state_nx = state;
    ld_stb   = 1'b0;
    case (state)
      S_IDLE: begin
        if (toggle && !empty && start_cond) begin
          state_nx = S_RD;
        end
      end
      S_RD:   state_nx = S_WAIT;
      S_WAIT: state_nx = S_EXEC;
      S_EXEC: begin
        ld_stb   = op_legal;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Edge detector, write pulse, opcode capture and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_q <= 1'b0;
      wen_q  <= 1'b0;
      op_q   <= 3'b000;
      err    <= 2'b00;
    end else begin
      push_q <= push;
      wen_q  <= do_write;
      if (state == S_WAIT) begin
        op_q <= opcode;
      end
      if (do_drop) begin
        err[0] <= 1'b1;
      end
      if (do_deq && !op_legal) begin
        err[1] <= 1'b1;
      end
    end
  end

  // Pointers advance after their access completes; both wrap at 16.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= 4'd0;
      rptr <= 4'd0;
    end else begin
      if (wen_q) begin
        wptr <= wptr + 4'd1;
      end
      if (do_deq) begin
        rptr <= rptr + 4'd1;
      end
    end
  end

  // Occupancy counter, clamped at 0 and 16.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 5'd0;
    end else begin
      case ({wen_q, do_deq})
        2'b10: if (count != DEPTH) count <= count + 5'd1;
        2'b01: if (count != 5'd0)  count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq_ctrl
//  Description : Directed self-checking bench for alu_seq_ctrl. A small
//                opcode memory behind radder stands in for the FIFO with
//                one cycle of read latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       push;
  logic       toggle;
  logic [2:0] opcode;
  logic [3:0] wradder;
  logic [3:0] radder;
  logic       wen;
  logic       ld_stb;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       busy;
  logic [1:0] err;

  logic [2:0] mem [16];
  int         tests;
  int         fails;

  alu_seq_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .toggle  (toggle),
    .opcode  (opcode),
    .wradder (wradder),
    .radder  (radder),
    .wen     (wen),
    .ld_stb  (ld_stb),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .busy    (busy),
    .err     (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // FIFO read model: data for radder appears one cycle later.
  always @(posedge clk) opcode <= mem[radder];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    push = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    for (int i = 0; i < 16; i++) mem[i] = 3'b000;
    toggle = 1'b0;
    do_reset();
    tests++; if (count !== 5'd0)   begin fails++; $display("FAIL reset_count got %0d want 0", count); end
    tests++; if ({empty, full, busy, wen, ld_stb} !== 5'b10000)
      begin fails++; $display("FAIL reset_flags got %b want 10000", {empty, full, busy, wen, ld_stb}); end
    tests++; if (err !== 2'b00)    begin fails++; $display("FAIL reset_err got %b want 00", err); end
    tests++; if ({wradder, radder} !== 8'h00)
      begin fails++; $display("FAIL reset_ptrs got %h want 00", {wradder, radder}); end
  endtask

  // Three presses in load mode, storing opcodes 001, 011, 100.
  task automatic test_load3;
    logic [2:0] ops [3];
    ops[0] = 3'b001; ops[1] = 3'b011; ops[2] = 3'b100;
    toggle = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem[i] = ops[i];
      push = 1'b1;
      tick();
      tests++; if (wen !== 1'b1 || wradder !== 4'(i))
        begin fails++; $display("FAIL load_wen[%0d] got wen=%b addr=%0d want wen=1 addr=%0d", i, wen, wradder, i); end
      push = 1'b0;
      tick();
      tests++; if (wen !== 1'b0)   begin fails++; $display("FAIL load_wen_off[%0d] got %b want 0", i, wen); end
    end
    tests++; if (count !== 5'd3 || empty !== 1'b0)
      begin fails++; $display("FAIL load_count got count=%0d empty=%b want 3/0", count, empty); end
  endtask

  // One dequeue via press; checks ld_stb timing, radder hold and advance.
  task automatic test_exec(input logic exp_ld, input logic [3:0] r0,
                           input logic [4:0] c_after, input logic [1:0] err_after);
    toggle = 1'b1;
    push = 1'b1;
    tick();
    tests++; if (busy !== 1'b1 || radder !== r0 || ld_stb !== 1'b0)
      begin fails++; $display("FAIL exec_rd got busy=%b radder=%0d ld=%b want 1/%0d/0", busy, radder, ld_stb, r0); end
    push = 1'b0;
    tick();
    tests++; if (radder !== r0 || ld_stb !== 1'b0)
      begin fails++; $display("FAIL exec_wait got radder=%0d ld=%b want %0d/0", radder, ld_stb, r0); end
    tick();
    tests++; if (ld_stb !== exp_ld || busy !== 1'b1)
      begin fails++; $display("FAIL exec_ld got ld=%b busy=%b want %b/1", ld_stb, busy, exp_ld); end
    tick();
    tests++; if (ld_stb !== 1'b0 || busy !== 1'b0 || radder !== r0 + 4'd1 || count !== c_after || err !== err_after)
      begin fails++; $display("FAIL exec_done got ld=%b busy=%b radder=%0d count=%0d err=%b want 0/0/%0d/%0d/%b",
                             ld_stb, busy, radder, count, err, r0 + 4'd1, c_after, err_after); end
  endtask

  // Press and toggle change during WAIT must neither abort nor enqueue.
  task automatic test_busy_ignore;
    toggle = 1'b1;
    push = 1'b1;
    tick();
    push = 1'b0;
    tick();
    push = 1'b1;
    toggle = 1'b0;
    tick();
    tests++; if (ld_stb !== 1'b1 || wen !== 1'b0)
      begin fails++; $display("FAIL busy_ld got ld=%b wen=%b want 1/0", ld_stb, wen); end
    push = 1'b0;
    tick();
    tests++; if (wen !== 1'b0 || count !== 5'd0 || empty !== 1'b1 || radder !== 4'd3 || busy !== 1'b0)
      begin fails++; $display("FAIL busy_done got wen=%b count=%0d empty=%b radder=%0d busy=%b want 0/0/1/3/0",
                             wen, count, empty, radder, busy); end
    // Empty queue in execute mode: a press must not start a sequence.
    toggle = 1'b1;
    push = 1'b1;
    tick();
    push = 1'b0;
    tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL empty_start got busy=%b want 0", busy); end
    tick();
  endtask

  // Fill to 16, then a 17th press is dropped and flagged.
  task automatic test_fill;
    do_reset();
    toggle = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem[i] = 3'b101;
      push = 1'b1;
      tick();
      push = 1'b0;
      tick();
    end
    tests++; if (count !== 5'd16 || full !== 1'b1 || wradder !== 4'd0)
      begin fails++; $display("FAIL fill_full got count=%0d full=%b wradder=%0d want 16/1/0", count, full, wradder); end
    push = 1'b1;
    tick();
    tests++; if (wen !== 1'b0)     begin fails++; $display("FAIL fill_drop_wen got %b want 0", wen); end
    push = 1'b0;
    tick();
    tests++; if (err !== 2'b01 || count !== 5'd16 || wradder !== 4'd0)
      begin fails++; $display("FAIL fill_drop got err=%b count=%0d wradder=%0d want 01/16/0", err, count, wradder); end
  endtask

  // Asynchronous reset in WAIT aborts the op; next press is normal.
  task automatic test_reset_wait;
    toggle = 1'b1;
    push = 1'b1;
    tick();
    push = 1'b0;
    tick();
    tests++; if (busy !== 1'b1)    begin fails++; $display("FAIL rw_busy got %b want 1", busy); end
    #2 rst = 1'b1;
    #1;
    tests++; if (busy !== 1'b0 || count !== 5'd0 || radder !== 4'd0 || wradder !== 4'd0 || ld_stb !== 1'b0 || err !== 2'b00)
      begin fails++; $display("FAIL rw_async got busy=%b count=%0d r=%0d w=%0d ld=%b err=%b want 0/0/0/0/0/00",
                             busy, count, radder, wradder, ld_stb, err); end
    tick();
    tests++; if (ld_stb !== 1'b0)  begin fails++; $display("FAIL rw_no_ld got %b want 0", ld_stb); end
    rst = 1'b0;
    toggle = 1'b0;
    tick();
    push = 1'b1;
    tick();
    tests++; if (wen !== 1'b1 || wradder !== 4'd0)
      begin fails++; $display("FAIL rw_after got wen=%b addr=%0d want 1/0", wen, wradder); end
    push = 1'b0;
    tick();
  endtask

`ifdef ALU_SEQ_AUTORUN_EN
  // Four queued ops drain on their own, one strobe every four cycles.
  task automatic test_autorun;
    int n;
    int last;
    do_reset();
    toggle = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem[i] = 3'b110;
      push = 1'b1;
      tick();
      push = 1'b0;
      tick();
    end
    toggle = 1'b1;
    n = 0;
    last = -1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (ld_stb === 1'b1) begin
        if (last >= 0) begin
          tests++; if (c - last !== 4)
            begin fails++; $display("FAIL auto_gap got %0d want 4", c - last); end
        end
        last = c;
        n++;
      end
    end
    tests++; if (n !== 4)          begin fails++; $display("FAIL auto_pulses got %0d want 4", n); end
    tests++; if (empty !== 1'b1 || busy !== 1'b0)
      begin fails++; $display("FAIL auto_end got empty=%b busy=%b want 1/0", empty, busy); end
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    push = 1'b0;
    toggle = 1'b0;
    opcode = 3'b000;
    test_reset();
    test_load3();
`ifdef ALU_SEQ_AUTORUN_EN
    test_fill();
    test_autorun();
`else
    test_exec(1'b1, 4'd0, 5'd2, 2'b00);
    test_exec(1'b0, 4'd1, 5'd1, 2'b10);
    test_busy_ignore();
    test_fill();
    test_reset_wait();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
